// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/decode boundary: fetch FSM encoding
// and instruction field positions.
package mips_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetchState_e;

  localparam int INSTR_WIDTH = 32;
  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 26;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register plus a one-entry skid buffer that catches an
// instruction returned while decode is stalled.
module if_id_register
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   capture,
  input  logic                   promote,
  input  logic                   bubble,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instrIn,
  input  logic [ADDR_WIDTH-1:0]  pc4In,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc4,
  output logic                   skidFull
);

  logic [INSTR_WIDTH-1:0] skidInstr;
  logic [ADDR_WIDTH-1:0]  skidPc4;

  // Flush wins over everything; promote drains the skid into IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (promote) begin
      valid <= 1'b1;
      instr <= skidInstr;
      pc4   <= skidPc4;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instrIn;
      pc4   <= pc4In;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidFull  <= 1'b0;
      skidInstr <= NOP_INSTR;
      skidPc4   <= '0;
    end else if (flush || promote) begin
      skidFull <= 1'b0;
    end else if (capture) begin
      skidFull  <= 1'b1;
      skidInstr <= instrIn;
      skidPc4   <= pc4In;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: owns the PC, issues one outstanding imem read at a time,
// and handles decode stalls and branch/jump redirects.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0]  if_id_pc4,
  output logic [5:0]             op
);

  fetchState_e state, nextState;
  logic [ADDR_WIDTH-1:0] pc, pcD, pcNext, pcNextD;
  logic [ADDR_WIDTH-1:0] pcPlus4, target;
  logic load, capture, promote, bubble, flush;
  logic skidFull;

  assign pcPlus4 = pc + ADDR_WIDTH'(4);
  assign target  = redirect_pc & ~ADDR_WIDTH'(3);

  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = pc;
  assign op        = if_id_instr[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= START;
      pc     <= RESET_PC;
      pcNext <= RESET_PC;
    end else begin
      state  <= nextState;
      pc     <= pcD;
      pcNext <= pcNextD;
    end
  end

  // In DRAIN the old address stays on the bus until the wrong-path ack;
  // the redirect target waits in pcNext.
  always_comb begin
    nextState = state;
    pcD       = pc;
    pcNextD   = pcNext;
    load      = 1'b0;
    capture   = 1'b0;
    promote   = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    case (state)
      START: begin
        nextState = REQ;
        if (redirect) begin
          flush = 1'b1;
          pcD   = target;
        end
      end
      REQ: begin
        if (redirect) begin
          flush = 1'b1;
          if (imem_ack) begin
            pcD = target;
          end else begin
            pcNextD   = target;
            nextState = DRAIN;
          end
        end else if (imem_ack) begin
          pcD = pcPlus4;
          if (stall) begin
            capture   = 1'b1;
            nextState = HOLD;
          end else begin
            load = 1'b1;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          flush     = 1'b1;
          pcD       = target;
          nextState = REQ;
        end else if (!stall) begin
          promote   = 1'b1;
          nextState = REQ;
        end
      end
      DRAIN: begin
        if (redirect) begin
          flush = 1'b1;
          if (imem_ack) begin
            pcD       = target;
            nextState = REQ;
          end else begin
            pcNextD = target;
          end
        end else if (imem_ack) begin
          pcD       = pcNext;
          nextState = REQ;
        end
      end
      default: nextState = START;
    endcase
  end

  if_id_register #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) ifIdReg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .capture (capture),
    .promote (promote),
    .bubble  (bubble),
    .flush   (flush),
    .instrIn (imem_rdata),
    .pc4In   (pcPlus4),
    .valid   (if_id_valid),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4),
    .skidFull(skidFull)
  );

  logic unusedSkid;
  assign unusedSkid = skidFull;

endmodule
